// File: rtl/detector_pulsacion.sv
// rtl/detector_pulsacion.sv - classifies a debounced button level into short, long and repeat pulses
// Four-state FSM with a shared high-sample counter; every output is registered.
module detector_pulsacion #(
    parameter int MIN_COUNT  = 1,
    parameter int LONG_COUNT = 100_000_000,
    parameter int REP_COUNT  = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic boton_in,
    output logic pulso_corto,
    output logic pulso_largo,
    output logic pulso_repetir,
    output logic presionado
);

    localparam int MAX_COUNT = (LONG_COUNT > REP_COUNT) ? LONG_COUNT : REP_COUNT;
    localparam int W         = $clog2(MAX_COUNT + 1);

    localparam logic [W-1:0] C_CERO = '0;
    localparam logic [W-1:0] C_UNO  = W'(1);
    localparam logic [W-1:0] C_MIN  = W'(MIN_COUNT);
    localparam logic [W-1:0] C_LONG = W'(LONG_COUNT);
    localparam logic [W-1:0] C_REP  = W'(REP_COUNT);

    typedef enum logic [1:0] {
        INICIO     = 2'd0,
        LIBRE      = 2'd1,
        PRESIONADO = 2'd2,
        LARGO      = 2'd3
    } estado_t;

    estado_t      r_estado;
    estado_t      w_estado_sig;
    logic [W-1:0] r_cuenta;
    logic [W-1:0] w_cuenta_sig;
    logic [W-1:0] w_cuenta_inc;
    logic         r_pulso_corto;
    logic         r_pulso_largo;
    logic         r_pulso_repetir;
    logic         r_presionado;
    logic         w_pulso_corto;
    logic         w_pulso_largo;
    logic         w_pulso_repetir;
    logic         w_presionado;

    assign w_cuenta_inc = r_cuenta + C_UNO;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado        <= INICIO;
            r_cuenta        <= C_CERO;
            r_pulso_corto   <= 1'b0;
            r_pulso_largo   <= 1'b0;
            r_pulso_repetir <= 1'b0;
            r_presionado    <= 1'b0;
        end else begin
            r_estado        <= w_estado_sig;
            r_cuenta        <= w_cuenta_sig;
            r_pulso_corto   <= w_pulso_corto;
            r_pulso_largo   <= w_pulso_largo;
            r_pulso_repetir <= w_pulso_repetir;
            r_presionado    <= w_presionado;
        end
    end

    // Pulses default low so each one lasts exactly one cycle.
    always_comb begin
        w_estado_sig    = r_estado;
        w_cuenta_sig    = r_cuenta;
        w_pulso_corto   = 1'b0;
        w_pulso_largo   = 1'b0;
        w_pulso_repetir = 1'b0;
        w_presionado    = r_presionado;
        case (r_estado)
            INICIO: begin
                // A level already high after reset is not a fresh press.
                if (!boton_in) begin
                    w_estado_sig = LIBRE;
                end
            end
            LIBRE: begin
                if (boton_in) begin
                    w_estado_sig = PRESIONADO;
                    w_cuenta_sig = C_UNO;
                    w_presionado = 1'b1;
                end
            end
            PRESIONADO: begin
                if (boton_in) begin
                    if (w_cuenta_inc == C_LONG) begin
                        w_pulso_largo = 1'b1;
                        w_cuenta_sig  = C_CERO;
                        w_estado_sig  = LARGO;
                    end else begin
                        w_cuenta_sig = w_cuenta_inc;
                    end
                end else begin
                    w_pulso_corto = (r_cuenta >= C_MIN);
                    w_estado_sig  = LIBRE;
                    w_presionado  = 1'b0;
                    w_cuenta_sig  = C_CERO;
                end
            end
            LARGO: begin
                if (boton_in) begin
                    if (REP_COUNT != 0) begin
                        if (w_cuenta_inc == C_REP) begin
                            w_pulso_repetir = 1'b1;
                            w_cuenta_sig    = C_CERO;
                        end else begin
                            w_cuenta_sig = w_cuenta_inc;
                        end
                    end
                end else begin
                    w_estado_sig = LIBRE;
                    w_presionado = 1'b0;
                    w_cuenta_sig = C_CERO;
                end
            end
            default: begin
                w_estado_sig = INICIO;
                w_cuenta_sig = C_CERO;
                w_presionado = 1'b0;
            end
        endcase
    end

    assign pulso_corto   = r_pulso_corto;
    assign pulso_largo   = r_pulso_largo;
    assign pulso_repetir = r_pulso_repetir;
    assign presionado    = r_presionado;

endmodule

// File: tb/tb_detector_pulsacion.sv
// tb/tb_detector_pulsacion.sv - directed bench for detector_pulsacion (REP_COUNT=4 and REP_COUNT=0 instances)
module tb_detector_pulsacion;

    logic clk;
    logic reset;
    logic boton_in;
    logic corto_a, largo_a, rep_a, pres_a;
    logic corto_b, largo_b, rep_b, pres_b;
    int   n_checks;
    int   n_errors;
    int   n_largo_b;

    detector_pulsacion #(.MIN_COUNT(3), .LONG_COUNT(10), .REP_COUNT(4)) dut_a (
        .clk(clk), .reset(reset), .boton_in(boton_in),
        .pulso_corto(corto_a), .pulso_largo(largo_a),
        .pulso_repetir(rep_a), .presionado(pres_a)
    );

    detector_pulsacion #(.MIN_COUNT(3), .LONG_COUNT(10), .REP_COUNT(0)) dut_b (
        .clk(clk), .reset(reset), .boton_in(boton_in),
        .pulso_corto(corto_b), .pulso_largo(largo_b),
        .pulso_repetir(rep_b), .presionado(pres_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vectors are {pulso_corto, pulso_largo, pulso_repetir, presionado}.
    task automatic chk_a(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {corto_a, largo_a, rep_a, pres_a};
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {corto_b, largo_b, rep_b, pres_b};
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply one sample, let the edge capture it, look at the outputs 1 ns later.
    task automatic step(input logic b);
        boton_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input logic b, input string tag, input logic [3:0] exp);
        step(b);
        chk_a(tag, exp);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        n_largo_b = 0;
        boton_in  = 1'b1;
        reset     = 1'b0;
        #1;
        chk_a("reset_a", 4'b0000);
        chk_b("reset_b", 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Held through reset: no events until a release then a new press
        for (int i = 0; i < 20; i++) step_chk(1'b1, "held_after_reset", 4'b0000);
        step_chk(1'b0, "held_release1", 4'b0000);
        step_chk(1'b0, "held_release2", 4'b0000);
        for (int i = 0; i < 5; i++) step_chk(1'b1, "held_press5", 4'b0001);
        step_chk(1'b0, "held_corto", 4'b1000);
        step_chk(1'b0, "held_corto_gone", 4'b0000);

        // Two-sample glitch is discarded, three samples make a short press
        step_chk(1'b1, "glitch_h1", 4'b0001);
        step_chk(1'b1, "glitch_h2", 4'b0001);
        step_chk(1'b0, "glitch_no_pulse", 4'b0000);
        step_chk(1'b0, "glitch_idle", 4'b0000);
        for (int i = 0; i < 3; i++) step_chk(1'b1, "min_press3", 4'b0001);
        step_chk(1'b0, "min_corto", 4'b1000);
        step_chk(1'b0, "min_idle", 4'b0000);

        // Nine samples: still short
        for (int i = 0; i < 9; i++) step_chk(1'b1, "nine_press", 4'b0001);
        step_chk(1'b0, "nine_corto", 4'b1000);
        step_chk(1'b0, "nine_idle", 4'b0000);

        // Ten samples: long, nothing on release
        for (int i = 0; i < 9; i++) step_chk(1'b1, "ten_press", 4'b0001);
        step_chk(1'b1, "ten_largo", 4'b0101);
        step_chk(1'b0, "ten_release_quiet", 4'b0000);
        step_chk(1'b0, "ten_idle", 4'b0000);

        // Eighteen samples: long at 10, repeat at 14 and 18
        for (int k = 1; k <= 18; k++) begin
            step(1'b1);
            if (k == 10) begin
                chk_a("rep18_largo", 4'b0101);
                chk_b("rep18_b_largo", 4'b0101);
            end else if (k == 14 || k == 18) begin
                chk_a("rep18_repetir", 4'b0011);
                chk_b("rep18_b_no_rep", 4'b0001);
            end else begin
                chk_a("rep18_held", 4'b0001);
            end
        end
        step_chk(1'b0, "rep18_release", 4'b0000);
        chk_b("rep18_b_release", 4'b0000);
        step_chk(1'b0, "rep18_idle", 4'b0000);

        // Forty samples: the REP_COUNT=0 instance gives exactly one long pulse
        for (int k = 1; k <= 40; k++) begin
            step(1'b1);
            if (largo_b) n_largo_b++;
            if (k == 10) begin
                chk_b("hold40_b_largo", 4'b0101);
                chk_a("hold40_a_largo", 4'b0101);
            end else begin
                chk_b("hold40_b_held", 4'b0001);
            end
            if (k > 10 && ((k - 10) % 4) == 0) chk_a("hold40_a_repetir", 4'b0011);
        end
        n_checks++;
        assert (n_largo_b == 1) else begin
            n_errors++;
            $error("FAIL hold40_largo_count: observed=%0d expected=1", n_largo_b);
        end
        step_chk(1'b0, "hold40_release", 4'b0000);
        chk_b("hold40_b_release", 4'b0000);
        step_chk(1'b0, "hold40_idle", 4'b0000);

        // Back-to-back: one low sample separates two presses
        for (int i = 0; i < 4; i++) step_chk(1'b1, "b2b_first", 4'b0001);
        step_chk(1'b0, "b2b_corto1", 4'b1000);
        for (int i = 0; i < 4; i++) step_chk(1'b1, "b2b_second", 4'b0001);
        step_chk(1'b0, "b2b_corto2", 4'b1000);
        step_chk(1'b0, "b2b_idle", 4'b0000);

        // Reset mid-press at high sample 6, then button still held after deassertion
        for (int i = 0; i < 6; i++) step_chk(1'b1, "rst_mid_press", 4'b0001);
        #3;
        reset = 1'b0;
        #1;
        chk_a("rst_mid_async_a", 4'b0000);
        chk_b("rst_mid_async_b", 4'b0000);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) step_chk(1'b1, "rst_still_held", 4'b0000);
        step_chk(1'b0, "rst_release", 4'b0000);
        for (int i = 0; i < 3; i++) step_chk(1'b1, "rst_new_press", 4'b0001);
        step_chk(1'b0, "rst_new_corto", 4'b1000);
        chk_b("rst_new_corto_b", 4'b1000);
        step_chk(1'b0, "rst_final_idle", 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
